// File: rtl/cp_len_scheduler.sv
// Per-symbol cyclic-prefix length scheduler: streams a programmable CP-length list on AXI-Stream.
// Optional double-buffered list with commit/swap when CP_SCHED_SHADOW_EN is defined.
module cp_len_scheduler #(
  parameter int CP_LEN_W = 12,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_wr_en,
  input  logic [IDX_W-1:0]    cfg_wr_addr,
  input  logic [CP_LEN_W-1:0] cfg_wr_data,
  input  logic [IDX_W-1:0]    cfg_last_idx,
  input  logic                cfg_restart,
  input  logic                cfg_commit,
  output logic [CP_LEN_W-1:0] m_cp_len_tdata,
  output logic                m_cp_len_tvalid,
  input  logic                m_cp_len_tready,
  output logic [IDX_W-1:0]    sym_idx,
  output logic                wrap,
  output logic                commit_pending
);

  localparam int DEPTH = 2 ** IDX_W;
`ifdef CP_SCHED_SHADOW_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    ptr_r, ptr_s;
  logic [CP_LEN_W-1:0] tdata_r, tdata_s;
  logic                tvalid_r, tvalid_s;
  logic [IDX_W-1:0]    sym_idx_r, sym_idx_s;
  logic                wrap_r, wrap_s;
  logic                restart_req_r, restart_req_s;
  logic                handshake_s;
  logic                at_last_s;
  logic                fetch_s;
  logic [IDX_W-1:0]    fetch_idx_s;
  logic [CP_LEN_W-1:0] fetch_data_s;
  logic [CP_LEN_W-1:0] list_r [NBANK][DEPTH];

`ifdef CP_SCHED_SHADOW_EN
  logic bank_r, bank_s;
  logic pending_r, pending_s;
`else
  logic unused_commit_s;
  assign unused_commit_s = cfg_commit;
`endif

  // List write port; storage is intentionally not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (cfg_wr_en) begin
`ifdef CP_SCHED_SHADOW_EN
      if (bank_r) begin
        list_r[0][cfg_wr_addr] <= cfg_wr_data;
      end else begin
        list_r[1][cfg_wr_addr] <= cfg_wr_data;
      end
`else
      list_r[0][cfg_wr_addr] <= cfg_wr_data;
`endif
    end
  end

  // Next-state, pointer advance, bank swap and fetch selection.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    tdata_s       = tdata_r;
    tvalid_s      = tvalid_r;
    sym_idx_s     = sym_idx_r;
    wrap_s        = 1'b0;
    restart_req_s = restart_req_r;
    fetch_s       = 1'b0;
    fetch_idx_s   = ptr_r;
    fetch_data_s  = {CP_LEN_W{1'b0}};
    handshake_s   = tvalid_r & m_cp_len_tready;
    at_last_s     = (ptr_r >= cfg_last_idx);

    case (state_r)
      ST_IDLE: begin
        restart_req_s = 1'b0;
        if (cfg_restart) begin
          fetch_idx_s = {IDX_W{1'b0}};
        end else begin
          fetch_idx_s = ptr_r;
        end
        ptr_s = fetch_idx_s;
        if (enable) begin
          fetch_s  = 1'b1;
          tvalid_s = 1'b1;
          state_s  = ST_VALID;
        end else begin
          tvalid_s = 1'b0;
          state_s  = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (handshake_s) begin
          wrap_s        = at_last_s;
          restart_req_s = 1'b0;
          // A restart seen during a stall is deferred to this handshake.
          if (cfg_restart || restart_req_r || at_last_s) begin
            fetch_idx_s = {IDX_W{1'b0}};
          end else begin
            fetch_idx_s = ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
          ptr_s = fetch_idx_s;
          if (enable) begin
            fetch_s  = 1'b1;
            tvalid_s = 1'b1;
            state_s  = ST_VALID;
          end else begin
            tvalid_s = 1'b0;
            state_s  = ST_IDLE;
          end
        end else begin
          if (cfg_restart) begin
            restart_req_s = 1'b1;
          end else begin
            restart_req_s = restart_req_r;
          end
        end
      end
      default: begin
        tvalid_s = 1'b0;
        state_s  = ST_IDLE;
      end
    endcase

`ifdef CP_SCHED_SHADOW_EN
    bank_s    = bank_r;
    pending_s = pending_r;
    if (pending_r) begin
      if (cfg_restart || (state_r == ST_IDLE) || (handshake_s && at_last_s)) begin
        bank_s    = ~bank_r;
        pending_s = 1'b0;
      end else begin
        pending_s = 1'b1;
      end
    end else if (cfg_commit) begin
      pending_s = 1'b1;
    end else begin
      pending_s = 1'b0;
    end
    if (bank_s) begin
      fetch_data_s = list_r[1][fetch_idx_s];
    end else begin
      fetch_data_s = list_r[0][fetch_idx_s];
    end
`else
    fetch_data_s = list_r[0][fetch_idx_s];
`endif

    if (fetch_s) begin
      tdata_s   = fetch_data_s;
      sym_idx_s = fetch_idx_s;
    end else begin
      tdata_s   = tdata_r;
      sym_idx_s = sym_idx_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= {IDX_W{1'b0}};
      tdata_r       <= {CP_LEN_W{1'b0}};
      tvalid_r      <= 1'b0;
      sym_idx_r     <= {IDX_W{1'b0}};
      wrap_r        <= 1'b0;
      restart_req_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      tdata_r       <= tdata_s;
      tvalid_r      <= tvalid_s;
      sym_idx_r     <= sym_idx_s;
      wrap_r        <= wrap_s;
      restart_req_r <= restart_req_s;
    end
  end

`ifdef CP_SCHED_SHADOW_EN
  // Active-bank select and pending-commit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r    <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      bank_r    <= bank_s;
      pending_r <= pending_s;
    end
  end
  assign commit_pending = pending_r;
`else
  assign commit_pending = 1'b0;
`endif

  assign m_cp_len_tdata  = tdata_r;
  assign m_cp_len_tvalid = tvalid_r;
  assign sym_idx         = sym_idx_r;
  assign wrap            = wrap_r;

endmodule
